// File: rtl/hyperbus_arbiter.sv
// hyperbus_arbiter: shares one hyperbus_fifo user-side port among NREQ requesters.
//   Commands are arbitrated round robin (or fixed priority when HBUS_ARB_FIXED_PRIO_EN
//   is defined) with at most one command every two cycles. Writes are throttled on the
//   TX FIFO ready flag plus a holdoff counter. A tag queue records the issuing requester
//   of every read so returned data is routed back in order.
// Configuration macro: HBUS_ARB_FIXED_PRIO_EN (defined: lowest eligible index wins).
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   req_rrq/req_wrq          per-requester read/write request levels, held until grant
//   req_adr/req_wdat         packed per-requester address / write data
//   req_gnt                  one-hot 1-cycle grant pulse
//   req_rvalid/req_rdat      one-hot read-data-valid pulse and returned data
//   fifo_rrq/fifo_wrq        command strobes to hyperbus_fifo
//   fifo_adr/fifo_tx_dat     command address / write data
//   fifo_tx_ready            TX FIFO empty indication
//   fifo_rx_dat/rx_valid     returned read data and its valid pulse
//   busy                     reads outstanding
//   err_orphan               sticky: read data returned with no read outstanding
module hyperbus_arbiter #(
  parameter int unsigned NREQ       = 2,
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned TAG_DEPTH  = 4,
  parameter int unsigned WR_HOLDOFF = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NREQ-1:0]              req_rrq,
  input  logic [NREQ-1:0]              req_wrq,
  input  logic [NREQ*ADDR_WIDTH-1:0]   req_adr,
  input  logic [NREQ*DATA_WIDTH-1:0]   req_wdat,
  output logic [NREQ-1:0]              req_gnt,
  output logic [NREQ-1:0]              req_rvalid,
  output logic [DATA_WIDTH-1:0]        req_rdat,
  output logic                         fifo_rrq,
  output logic                         fifo_wrq,
  output logic [ADDR_WIDTH-1:0]        fifo_adr,
  output logic [DATA_WIDTH-1:0]        fifo_tx_dat,
  input  logic                         fifo_tx_ready,
  input  logic [DATA_WIDTH-1:0]        fifo_rx_dat,
  input  logic                         fifo_rx_valid,
  output logic                         busy,
  output logic                         err_orphan
);

  localparam int unsigned IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int unsigned PTR_W = (TAG_DEPTH > 1) ? $clog2(TAG_DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(TAG_DEPTH) + 1;
  localparam int unsigned HO_W  = (WR_HOLDOFF > 0) ? $clog2(WR_HOLDOFF + 1) : 1;

  typedef enum logic {S_IDLE = 1'b0, S_ISSUE = 1'b1} state_t;

  state_t state_q, state_d;

  // command side
  logic [NREQ-1:0]       gnt_q, gnt_d;
  logic                  fifo_rrq_q, fifo_rrq_d;
  logic                  fifo_wrq_q, fifo_wrq_d;
  logic [ADDR_WIDTH-1:0] fifo_adr_q, fifo_adr_d;
  logic [DATA_WIDTH-1:0] fifo_tx_dat_q, fifo_tx_dat_d;
  logic [IDX_W-1:0]      win_idx_q, win_idx_d;
  logic [HO_W-1:0]       holdoff_q, holdoff_d;
`ifndef HBUS_ARB_FIXED_PRIO_EN
  logic [IDX_W-1:0]      rr_ptr_q, rr_ptr_d;
  logic [IDX_W-1:0]      cand;
`endif

  // read return side
  logic [IDX_W-1:0]      tag_mem_q [TAG_DEPTH];
  logic [IDX_W-1:0]      tag_mem_d [TAG_DEPTH];
  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]      tag_cnt_q, tag_cnt_d;
  logic [NREQ-1:0]       rvalid_q, rvalid_d;
  logic [DATA_WIDTH-1:0] rdat_q, rdat_d;
  logic                  busy_q, busy_d;
  logic                  orphan_q, orphan_d;

  // arbitration
  logic                  rd_ok, wr_ok;
  logic [NREQ-1:0]       elig_rd, elig;
  logic                  win_found;
  logic [IDX_W-1:0]      win_idx;
  logic                  win_is_rd;
  logic                  push, pop, orphan_evt;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(TAG_DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // A pop in this cycle frees a tag slot before the granted read is pushed in ISSUE.
  always_comb begin : eligibility
    rd_ok   = (tag_cnt_q < CNT_W'(TAG_DEPTH)) || fifo_rx_valid;
    wr_ok   = fifo_tx_ready && (holdoff_q == '0);
    elig_rd = req_rrq & {NREQ{rd_ok}};
    elig    = elig_rd | (req_wrq & {NREQ{wr_ok}});
  end

  // Winner search.
  always_comb begin : arb_search
    win_found = 1'b0;
    win_idx   = '0;
`ifdef HBUS_ARB_FIXED_PRIO_EN
    // Scan high to low so the lowest eligible index is the last to overwrite.
    for (int i = int'(NREQ) - 1; i >= 0; i--) begin
      if (elig[IDX_W'(i)]) begin
        win_found = 1'b1;
        win_idx   = IDX_W'(i);
      end
    end
`else
    cand = '0;
    for (int k = 1; k <= int'(NREQ); k++) begin
      cand = IDX_W'((int'(rr_ptr_q) + k) % int'(NREQ));
      if (!win_found && elig[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
`endif
    win_is_rd = elig_rd[win_idx];
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // FSM next state: a grant always takes exactly one ISSUE cycle.
  always_comb begin : fsm_next
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (win_found) state_d = S_ISSUE;
      S_ISSUE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // FSM outputs: strobes and grant are registered so they are high only during ISSUE.
  always_comb begin : fsm_out
    gnt_d         = '0;
    fifo_rrq_d    = 1'b0;
    fifo_wrq_d    = 1'b0;
    fifo_adr_d    = fifo_adr_q;
    fifo_tx_dat_d = fifo_tx_dat_q;
    win_idx_d     = win_idx_q;
    holdoff_d     = (holdoff_q != '0) ? holdoff_q - HO_W'(1) : holdoff_q;
`ifndef HBUS_ARB_FIXED_PRIO_EN
    rr_ptr_d      = rr_ptr_q;
`endif
    if (state_q == S_IDLE && win_found) begin
      gnt_d      = NREQ'(1) << win_idx;
      fifo_rrq_d = win_is_rd;
      fifo_wrq_d = !win_is_rd;
      fifo_adr_d = ADDR_WIDTH'(req_adr >> (ADDR_WIDTH * 32'(win_idx)));
      win_idx_d  = win_idx;
`ifndef HBUS_ARB_FIXED_PRIO_EN
      rr_ptr_d   = win_idx;
`endif
      if (!win_is_rd) begin
        fifo_tx_dat_d = DATA_WIDTH'(req_wdat >> (DATA_WIDTH * 32'(win_idx)));
        holdoff_d     = HO_W'(WR_HOLDOFF);
      end
    end
  end

  // Tag queue and read-data routing.
  always_comb begin : tag_queue
    push       = fifo_rrq_q;
    pop        = fifo_rx_valid && (tag_cnt_q != '0);
    orphan_evt = fifo_rx_valid && (tag_cnt_q == '0);
    tag_mem_d  = tag_mem_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    tag_cnt_d  = tag_cnt_q;
    if (push) begin
      tag_mem_d[wr_ptr_q] = win_idx_q;
      wr_ptr_d            = ptr_inc(wr_ptr_q);
    end
    if (pop) rd_ptr_d = ptr_inc(rd_ptr_q);
    case ({push, pop})
      2'b10:   tag_cnt_d = tag_cnt_q + CNT_W'(1);
      2'b01:   tag_cnt_d = tag_cnt_q - CNT_W'(1);
      default: tag_cnt_d = tag_cnt_q;
    endcase
    rvalid_d = pop ? (NREQ'(1) << tag_mem_q[rd_ptr_q]) : '0;
    rdat_d   = pop ? fifo_rx_dat : rdat_q;
    busy_d   = (tag_cnt_d != '0);
    orphan_d = orphan_q | orphan_evt;
  end

  // Datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      gnt_q         <= '0;
      fifo_rrq_q    <= 1'b0;
      fifo_wrq_q    <= 1'b0;
      fifo_adr_q    <= '0;
      fifo_tx_dat_q <= '0;
      win_idx_q     <= '0;
      holdoff_q     <= '0;
`ifndef HBUS_ARB_FIXED_PRIO_EN
      rr_ptr_q      <= IDX_W'(NREQ - 1);
`endif
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      tag_cnt_q     <= '0;
      rvalid_q      <= '0;
      rdat_q        <= '0;
      busy_q        <= 1'b0;
      orphan_q      <= 1'b0;
    end else begin
      gnt_q         <= gnt_d;
      fifo_rrq_q    <= fifo_rrq_d;
      fifo_wrq_q    <= fifo_wrq_d;
      fifo_adr_q    <= fifo_adr_d;
      fifo_tx_dat_q <= fifo_tx_dat_d;
      win_idx_q     <= win_idx_d;
      holdoff_q     <= holdoff_d;
`ifndef HBUS_ARB_FIXED_PRIO_EN
      rr_ptr_q      <= rr_ptr_d;
`endif
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      tag_cnt_q     <= tag_cnt_d;
      rvalid_q      <= rvalid_d;
      rdat_q        <= rdat_d;
      busy_q        <= busy_d;
      orphan_q      <= orphan_d;
    end
  end

  // Tag storage needs no reset: an entry is only read after it has been written.
  always_ff @(posedge clk) begin
    tag_mem_q <= tag_mem_d;
  end

  assign req_gnt     = gnt_q;
  assign req_rvalid  = rvalid_q;
  assign req_rdat    = rdat_q;
  assign fifo_rrq    = fifo_rrq_q;
  assign fifo_wrq    = fifo_wrq_q;
  assign fifo_adr    = fifo_adr_q;
  assign fifo_tx_dat = fifo_tx_dat_q;
  assign busy        = busy_q;
  assign err_orphan  = orphan_q;

endmodule
